// File: rtl/video_dma_pkg.sv
// Shared types and constants for the video DMA read controller.
package video_dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SPACE,
        REQ,
        DATA,
        NEXT,
        FRAME_WAIT
    } dmaState_t;

    localparam logic [15:0] cWdogLimit = 16'hFFFF;

    // Wide enough to hold the full burst length, not just its last index.
    function automatic int beatCntWidth(input int burstLength);
        return $clog2(burstLength) + 1;
    endfunction

endpackage

// File: rtl/video_dma_adrs_gen.sv
// Address generator: CSR shadow registers, current burst address, next/end compare and UFI packing.
module video_dma_adrs_gen
    import video_dma_pkg::*;
#(
    parameter int         pUfiAdrsBusWidth = 32,
    parameter logic [3:0] pUfiAdrsMap      = 4'h2,
    parameter int         pDmaAdrsWidth    = 18
) (
    input  logic                        iSCLK,
    input  logic                        inSRST,
    input  logic                        iLoad,
    input  logic                        iAdvance,
    input  logic                        iDmaCycleEnable,
    input  logic [pDmaAdrsWidth-1:0]    iDmaAdrsStart,
    input  logic [pDmaAdrsWidth-1:0]    iDmaAdrsEnd,
    input  logic [pDmaAdrsWidth-1:0]    iDmaAdrsAdd,
    output logic                        oMore,
    output logic                        oCycle,
    output logic [pUfiAdrsBusWidth-1:0] oUfiAdrs
);

    logic [pDmaAdrsWidth-1:0] rCurAdrs;
    logic [pDmaAdrsWidth-1:0] rAdrsEnd;
    logic [pDmaAdrsWidth-1:0] rAdrsAdd;
    logic                     rCycle;
    logic [pDmaAdrsWidth:0]   wNxt;

    // One extra bit so a carry-out always reads as "past the end".
    assign wNxt     = {1'b0, rCurAdrs} + {1'b0, rAdrsAdd};
    assign oMore    = (rAdrsAdd != '0) && (wNxt < {1'b0, rAdrsEnd});
    assign oCycle   = rCycle;
    assign oUfiAdrs = {pUfiAdrsMap, {(pUfiAdrsBusWidth - 4 - pDmaAdrsWidth){1'b0}}, rCurAdrs};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge iSCLK or negedge inSRST) begin
        if (!inSRST) begin
            rCurAdrs <= '0;
            rAdrsEnd <= '0;
            rAdrsAdd <= '0;
            rCycle   <= 1'b0;
        end else if (iLoad) begin
            rCurAdrs <= iDmaAdrsStart;
            rAdrsEnd <= iDmaAdrsEnd;
            rAdrsAdd <= iDmaAdrsAdd;
            rCycle   <= iDmaCycleEnable;
        end else if (iAdvance) begin
            rCurAdrs <= wNxt[pDmaAdrsWidth-1:0];
        end
    end

endmodule

// File: rtl/video_dma_read_ctrl.sv
// Video DMA read controller: UFI burst reads from the frame buffer into the video line FIFO.
// Define VIDEO_DMA_TIMEOUT_EN to add the DATA-phase watchdog and the oDmaTimeout port.
module video_dma_read_ctrl
    import video_dma_pkg::*;
#(
    parameter int         pUfiDqBusWidth   = 16,
    parameter int         pUfiAdrsBusWidth = 32,
    parameter logic [3:0] pUfiAdrsMap      = 4'h2,
    parameter int         pDmaAdrsWidth    = 18,
    parameter int         pDmaBurstLength  = 256,
    parameter int         pFifoDepth       = 512
) (
    input  logic                        iSCLK,
    input  logic                        inSRST,
    input  logic                        iDmaEnable,
    input  logic                        iDmaCycleEnable,
    input  logic [pDmaAdrsWidth-1:0]    iDmaAdrsStart,
    input  logic [pDmaAdrsWidth-1:0]    iDmaAdrsEnd,
    input  logic [pDmaAdrsWidth-1:0]    iDmaAdrsAdd,
    input  logic                        iFrameStart,
    input  logic [$clog2(pFifoDepth):0] iFifoFree,
    output logic                        oDmaDone,
`ifdef VIDEO_DMA_TIMEOUT_EN
    output logic                        oDmaTimeout,
`endif
    output logic                        oMUfiReq,
    output logic [pUfiAdrsBusWidth-1:0] oMUfiAdrs,
    input  logic                        iMUfiRdy,
    input  logic [pUfiDqBusWidth-1:0]   iMUfiRd,
    input  logic                        iMUfiRvd,
    output logic [pUfiDqBusWidth-1:0]   oWd,
    output logic                        oWe
);

    localparam int cBeatW = beatCntWidth(pDmaBurstLength);
    localparam int cFreeW = $clog2(pFifoDepth) + 1;
    localparam logic [cBeatW-1:0] cLastBeat   = cBeatW'(pDmaBurstLength - 1);
    localparam logic [cFreeW-1:0] cBurstWords = cFreeW'(pDmaBurstLength);

    dmaState_t                   rState;
    dmaState_t                   wNextState;
    logic [cBeatW-1:0]           rBeatCnt;
    logic                        rStopReq;
    logic                        wStop;
    logic                        wAccept;
    logic                        wBeat;
    logic                        wLastBeat;
    logic                        wBurstEnd;
    logic                        wFillBusy;
    logic                        wLoad;
    logic                        wAdvance;
    logic                        wSetDone;
    logic                        wMore;
    logic                        wCycle;
    logic [pUfiAdrsBusWidth-1:0] wPackedAdrs;

    video_dma_adrs_gen #(
        .pUfiAdrsBusWidth (pUfiAdrsBusWidth),
        .pUfiAdrsMap      (pUfiAdrsMap),
        .pDmaAdrsWidth    (pDmaAdrsWidth)
    ) uAdrsGen (
        .iSCLK           (iSCLK),
        .inSRST          (inSRST),
        .iLoad           (wLoad),
        .iAdvance        (wAdvance),
        .iDmaCycleEnable (iDmaCycleEnable),
        .iDmaAdrsStart   (iDmaAdrsStart),
        .iDmaAdrsEnd     (iDmaAdrsEnd),
        .iDmaAdrsAdd     (iDmaAdrsAdd),
        .oMore           (wMore),
        .oCycle          (wCycle),
        .oUfiAdrs        (wPackedAdrs)
    );

    assign wStop     = rStopReq || !iDmaEnable;
    assign wAccept   = (rState == REQ) && iMUfiRdy;
    assign wBeat     = (rState == DATA) && iMUfiRvd;
    assign wLastBeat = wBeat && (rBeatCnt == cLastBeat);
    assign oMUfiAdrs = oMUfiReq ? wPackedAdrs : '0;

`ifdef VIDEO_DMA_TIMEOUT_EN
    logic [15:0]       rWdog;
    logic [cBeatW-1:0] rFillCnt;
    logic              wTimeout;

    assign wTimeout  = (rState == DATA) && !iMUfiRvd && (rWdog == cWdogLimit);
    assign wBurstEnd = wLastBeat || wTimeout;
    assign wFillBusy = (rFillCnt != '0);

    // The missing beats are replaced by zeros so the line in the FIFO stays aligned.
    always_ff @(posedge iSCLK or negedge inSRST) begin
        if (!inSRST) begin
            rWdog       <= '0;
            rFillCnt    <= '0;
            oDmaTimeout <= 1'b0;
        end else begin
            rWdog <= ((rState == DATA) && !iMUfiRvd) ? rWdog + 16'd1 : 16'd0;
            if (wTimeout)
                rFillCnt <= cBeatW'(pDmaBurstLength) - rBeatCnt;
            else if (wFillBusy)
                rFillCnt <= rFillCnt - cBeatW'(1);
            if (wTimeout)
                oDmaTimeout <= 1'b1;
            else if (!iDmaEnable)
                oDmaTimeout <= 1'b0;
        end
    end
`else
    assign wBurstEnd = wLastBeat;
    assign wFillBusy = 1'b0;
`endif

    always_ff @(posedge iSCLK or negedge inSRST) begin
        if (!inSRST)
            rState <= IDLE;
        else
            rState <= wNextState;
    end

    // NOTE: defaults first so no path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        wNextState = rState;
        case (rState)
            IDLE:       if (iDmaEnable && !oDmaDone) wNextState = WAIT_SPACE;
            WAIT_SPACE: if (!iDmaEnable) wNextState = IDLE;
                        else if (iFifoFree >= cBurstWords) wNextState = REQ;
            REQ:        if (iMUfiRdy) wNextState = DATA;
                        else if (!iDmaEnable) wNextState = IDLE;
            DATA:       if (wBurstEnd) wNextState = NEXT;
            NEXT:       if (!wFillBusy) begin
                            if (wStop)       wNextState = IDLE;
                            else if (wMore)  wNextState = WAIT_SPACE;
                            else if (wCycle) wNextState = FRAME_WAIT;
                            else             wNextState = IDLE;
                        end
            FRAME_WAIT: if (!iDmaEnable) wNextState = IDLE;
                        else if (iFrameStart) wNextState = WAIT_SPACE;
            default:    wNextState = IDLE;
        endcase
    end

    always_comb begin
        oMUfiReq = 1'b0;
        wLoad    = 1'b0;
        wAdvance = 1'b0;
        wSetDone = 1'b0;
        case (rState)
            IDLE:       wLoad = iDmaEnable && !oDmaDone;
            REQ:        oMUfiReq = 1'b1;
            NEXT:       if (!wFillBusy && !wStop) begin
                            wAdvance = wMore;
                            wSetDone = !wMore && !wCycle;
                        end
            FRAME_WAIT: wLoad = iDmaEnable && iFrameStart;
            default:    ;
        endcase
    end

    // An enable drop mid-burst is remembered until the burst has drained.
    always_ff @(posedge iSCLK or negedge inSRST) begin
        if (!inSRST) begin
            rBeatCnt <= '0;
            rStopReq <= 1'b0;
        end else begin
            if (wAccept)
                rBeatCnt <= '0;
            else if (wBeat)
                rBeatCnt <= rBeatCnt + cBeatW'(1);
            rStopReq <= ((rState == DATA) || (rState == NEXT)) && wStop;
        end
    end

    always_ff @(posedge iSCLK or negedge inSRST) begin
        if (!inSRST) begin
            oWe      <= 1'b0;
            oWd      <= '0;
            oDmaDone <= 1'b0;
        end else begin
            oWe <= wBeat || wFillBusy;
            oWd <= wFillBusy ? '0 : iMUfiRd;
            if (wSetDone)
                oDmaDone <= 1'b1;
            else if (!iDmaEnable)
                oDmaDone <= 1'b0;
        end
    end

endmodule

// File: tb/tb_video_dma_read_ctrl.sv
// Randomized bench for video_dma_read_ctrl: UFI slave model plus address/data scoreboard.
`timescale 1ns/1ps
module tb_video_dma_read_ctrl;

    localparam int cBurst = 256;

    logic        iSCLK = 1'b0;
    logic        inSRST;
    logic        iDmaEnable;
    logic        iDmaCycleEnable;
    logic [17:0] iDmaAdrsStart;
    logic [17:0] iDmaAdrsEnd;
    logic [17:0] iDmaAdrsAdd;
    logic        iFrameStart;
    logic [9:0]  iFifoFree;
    logic        oDmaDone;
`ifdef VIDEO_DMA_TIMEOUT_EN
    logic        oDmaTimeout;
`endif
    logic        oMUfiReq;
    logic [31:0] oMUfiAdrs;
    logic        iMUfiRdy;
    logic [15:0] iMUfiRd;
    logic        iMUfiRvd;
    logic [15:0] oWd;
    logic        oWe;

    always #5 iSCLK = ~iSCLK;

    video_dma_read_ctrl uDut (
        .iSCLK           (iSCLK),
        .inSRST          (inSRST),
        .iDmaEnable      (iDmaEnable),
        .iDmaCycleEnable (iDmaCycleEnable),
        .iDmaAdrsStart   (iDmaAdrsStart),
        .iDmaAdrsEnd     (iDmaAdrsEnd),
        .iDmaAdrsAdd     (iDmaAdrsAdd),
        .iFrameStart     (iFrameStart),
        .iFifoFree       (iFifoFree),
        .oDmaDone        (oDmaDone),
`ifdef VIDEO_DMA_TIMEOUT_EN
        .oDmaTimeout     (oDmaTimeout),
`endif
        .oMUfiReq        (oMUfiReq),
        .oMUfiAdrs       (oMUfiAdrs),
        .iMUfiRdy        (iMUfiRdy),
        .iMUfiRd         (iMUfiRd),
        .iMUfiRvd        (iMUfiRvd),
        .oWd             (oWd),
        .oWe             (oWe)
    );

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [17:0] expAdrsQ[$];
    logic [15:0] expQ[$];
    int          slvBeatsLeft = 0;
    int          slvBeatsDone = 0;
    int          slvStopAt = -1;
    bit          slvHoldRdy = 1'b0;
    int          weCnt = 0;
    int          reqCnt = 0;
    int          lastWeCyc = 0;
    int          fillExp = 0;
    int          zeroCnt = 0;
    int          runReq0 = 0;
    int          runWe0 = 0;
    int          runBursts = 0;
    bit          sawDone = 1'b0;
    bit          sawReq = 1'b0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One clock: observe outputs on the falling edge, then act as the UFI slave.
    task automatic tick();
        @(negedge iSCLK);
        cyc++;
        if (oDmaDone) sawDone = 1'b1;
        if (oMUfiReq) sawReq = 1'b1;
        if (oWe) begin
            weCnt++;
            lastWeCyc = cyc;
            if (expQ.size() != 0)
                check("wr_data", oWd, expQ.pop_front());
            else if (fillExp > 0) begin
                check("fill_zero", oWd, 0);
                fillExp--;
                zeroCnt++;
            end else
                check("wr_extra", expQ.size(), 1);
        end
        iMUfiRvd = 1'b0;
        if (iMUfiRdy) begin
            iMUfiRdy = 1'b0;
            slvBeatsLeft = cBurst;
            slvBeatsDone = 0;
        end else if (slvBeatsLeft > 0) begin
            if (slvBeatsDone != slvStopAt && $urandom_range(0, 3) != 0) begin
                iMUfiRvd = 1'b1;
                iMUfiRd = 16'($urandom);
                expQ.push_back(iMUfiRd);
                slvBeatsLeft--;
                slvBeatsDone++;
            end
        end else if (oMUfiReq && !slvHoldRdy && $urandom_range(0, 2) == 0) begin
            iMUfiRdy = 1'b1;
            reqCnt++;
            if (expAdrsQ.size() == 0)
                check("req_extra", expAdrsQ.size(), 1);
            else
                check("req_adrs", oMUfiAdrs, {4'h2, 10'h0, expAdrsQ.pop_front()});
        end
    endtask

    // Reference burst list: Start, then Start+k*Add while below End; Add=0 stops after one.
    task automatic planRun(input int s, input int e, input int a);
        int cur = s;
        expAdrsQ.push_back(18'(cur));
        while (a != 0 && cur + a < e) begin
            cur = cur + a;
            expAdrsQ.push_back(18'(cur));
        end
    endtask

    task automatic startRun(input int s, input int e, input int a, input bit cycleEn);
        iDmaAdrsStart   = 18'(s);
        iDmaAdrsEnd     = 18'(e);
        iDmaAdrsAdd     = 18'(a);
        iDmaCycleEnable = cycleEn;
        planRun(s, e, a);
        runReq0      = reqCnt;
        runWe0       = weCnt;
        runBursts    = expAdrsQ.size();
        slvBeatsDone = 0;
        iDmaEnable   = 1'b1;
    endtask

    task automatic finishOneShot(input string tag);
        for (int i = 0; i < 8000 && !oDmaDone; i++) tick();
        check({tag, "_done"}, oDmaDone, 1);
        check({tag, "_done_lat"}, 64'((cyc - lastWeCyc) <= 2), 1);
        check({tag, "_reqs"}, reqCnt - runReq0, runBursts);
        check({tag, "_writes"}, weCnt - runWe0, runBursts * cBurst);
        iDmaEnable = 1'b0;
        tick();
        check({tag, "_done_clr"}, oDmaDone, 0);
    endtask

    task automatic waitQuiet(input string tag);
        for (int i = 0; i < 6000 && (expAdrsQ.size() != 0 || slvBeatsLeft != 0 ||
                                     expQ.size() != 0 || iMUfiRdy); i++) tick();
        repeat (8) tick();
        check({tag, "_pending"}, expAdrsQ.size() + expQ.size() + slvBeatsLeft, 0);
    endtask

    task automatic pulseFrame();
        iFrameStart = 1'b1;
        tick();
        iFrameStart = 1'b0;
    endtask

    initial begin : main
        logic [31:0] adrs0;
        bit          stable;

        inSRST = 1'b0;
        iDmaEnable = 1'b0;
        iDmaCycleEnable = 1'b0;
        iDmaAdrsStart = '0;
        iDmaAdrsEnd = '0;
        iDmaAdrsAdd = '0;
        iFrameStart = 1'b0;
        iFifoFree = 10'd512;
        iMUfiRdy = 1'b0;
        iMUfiRd = '0;
        iMUfiRvd = 1'b0;
        repeat (3) tick();
        check("rst_req", oMUfiReq, 0);
        check("rst_adrs", oMUfiAdrs, 0);
        check("rst_we", oWe, 0);
        check("rst_wd", oWd, 0);
        check("rst_done", oDmaDone, 0);
`ifdef VIDEO_DMA_TIMEOUT_EN
        check("rst_timeout", oDmaTimeout, 0);
`endif
        inSRST = 1'b1;
        repeat (2) tick();
        check("idle_req", oMUfiReq, 0);

        // Four bursts, one-shot.
        startRun(18'h0, 18'h400, 18'h100, 1'b0);
        finishOneShot("four");

        // FIFO space threshold.
        iFifoFree = 10'd255;
        sawReq = 1'b0;
        startRun(18'h1000, 18'h1100, 18'h100, 1'b0);
        repeat (20) tick();
        check("fifo255_noreq", sawReq, 0);
        iFifoFree = 10'd256;
        tick();
        check("fifo256_req", oMUfiReq, 1);
        finishOneShot("fifo");
        iFifoFree = 10'd512;

        // Request held against a stalled bus; degenerate window (Start >= End).
        slvHoldRdy = 1'b1;
        startRun(18'h2340, 18'h2000, 18'h40, 1'b0);
        for (int i = 0; i < 50 && !oMUfiReq; i++) tick();
        adrs0 = oMUfiAdrs;
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (!(oMUfiReq && oMUfiAdrs == adrs0)) stable = 1'b0;
        end
        check("req_stable", stable, 1);
        check("req_hold_adrs", adrs0, 32'h2000_2340);
        slvHoldRdy = 1'b0;
        for (int i = 0; i < 50 && !iMUfiRdy; i++) tick();
        tick();
        check("req_drop_after_acc", oMUfiReq, 0);
        finishOneShot("degen");

        // Add = 0 ends after a single burst.
        startRun(18'h100, 18'h800, 18'h0, 1'b0);
        finishOneShot("add0");

        // Enable drop while the request is still pending.
        slvHoldRdy = 1'b1;
        startRun(18'h8000, 18'h8100, 18'h100, 1'b0);
        for (int i = 0; i < 50 && !oMUfiReq; i++) tick();
        iDmaEnable = 1'b0;
        tick();
        check("req_withdraw", oMUfiReq, 0);
        expAdrsQ.delete();
        slvHoldRdy = 1'b0;
        repeat (5) tick();
        check("req_withdraw_done", oDmaDone, 0);

        // Randomized one-shot windows.
        for (int k = 0; k < 3; k++) begin
            int s;
            s = $urandom_range(0, 255) * 256;
            startRun(s, s + $urandom_range(0, 3) * 256, $urandom_range(0, 3) * 128, 1'b0);
            finishOneShot("rnd");
        end

        // Cyclic mode over three frames, Start changed during frame 2.
        sawDone = 1'b0;
        startRun(18'h3000, 18'h3200, 18'h100, 1'b1);
        waitQuiet("frame1");
        planRun(18'h3000, 18'h3200, 18'h100);
        pulseFrame();
        for (int i = 0; i < 500 && (reqCnt - runReq0) < 3; i++) tick();
        iDmaAdrsStart = 18'h5000;
        pulseFrame();
        waitQuiet("frame2");
        planRun(18'h5000, 18'h3200, 18'h100);
        pulseFrame();
        waitQuiet("frame3");
        check("cyc_no_done", sawDone, 0);
        check("cyc_reqs", reqCnt - runReq0, 5);
        check("cyc_writes", weCnt - runWe0, 5 * cBurst);
        iDmaEnable = 1'b0;
        repeat (3) tick();

        // Enable drop at beat 100: burst completes, no further requests, no done.
        startRun(18'h0, 18'h400, 18'h100, 1'b0);
        for (int i = 0; i < 2000 && !(reqCnt > runReq0 && slvBeatsDone >= 100); i++) tick();
        iDmaEnable = 1'b0;
        expAdrsQ.delete();
        waitQuiet("drop");
        check("drop_writes", weCnt - runWe0, cBurst);
        check("drop_reqs", reqCnt - runReq0, 1);
        check("drop_no_done", oDmaDone, 0);

        // Asynchronous reset in the middle of a burst.
        startRun(18'h100, 18'h200, 18'h100, 1'b0);
        for (int i = 0; i < 2000 && !(reqCnt > runReq0 && slvBeatsDone >= 50); i++) tick();
        inSRST = 1'b0;
        #1;
        check("arst_req", oMUfiReq, 0);
        check("arst_adrs", oMUfiAdrs, 0);
        check("arst_we", oWe, 0);
        check("arst_wd", oWd, 0);
        check("arst_done", oDmaDone, 0);
        iMUfiRvd = 1'b0;
        iMUfiRdy = 1'b0;
        slvBeatsLeft = 0;
        expQ.delete();
        expAdrsQ.delete();
        iDmaEnable = 1'b0;
        repeat (2) tick();
        inSRST = 1'b1;
        repeat (2) tick();

`ifdef VIDEO_DMA_TIMEOUT_EN
        // Read data stops after 10 beats: watchdog fires and zero-fills the burst.
        startRun(18'h400, 18'h500, 18'h100, 1'b0);
        slvStopAt = 10;
        for (int i = 0; i < 70000 && !oDmaTimeout; i++) tick();
        check("wdog_fired", oDmaTimeout, 1);
        check("wdog_beats", slvBeatsDone, 10);
        slvBeatsLeft = 0;
        slvStopAt = -1;
        fillExp = cBurst - 10;
        zeroCnt = 0;
        for (int i = 0; i < 1000 && !oDmaDone; i++) tick();
        check("wdog_zero_words", zeroCnt, 246);
        check("wdog_writes", weCnt - runWe0, cBurst);
        check("wdog_done", oDmaDone, 1);
        iDmaEnable = 1'b0;
        tick();
        check("wdog_clr", oDmaTimeout, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
